// File: rtl/decode_pkg.sv
// Shared decode definitions: opcodes, instruction field positions, immediate kinds
// and the per-opcode control decode used by decode_stage_pipe.
package decode_pkg;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_AND  = 4'h2;
  localparam logic [3:0] OP_OR   = 4'h3;
  localparam logic [3:0] OP_ADDI = 4'h4;
  localparam logic [3:0] OP_LW   = 4'h5;
  localparam logic [3:0] OP_SW   = 4'h6;
  localparam logic [3:0] OP_BEQ  = 4'h7;
  localparam logic [3:0] OP_LUI  = 4'h8;
  localparam logic [3:0] OP_JAL  = 4'h9;

  localparam int unsigned OP_MSB  = 15;
  localparam int unsigned OP_LSB  = 12;
  localparam int unsigned RS1_MSB = 11;
  localparam int unsigned RS1_LSB = 8;
  localparam int unsigned RD_MSB  = 7;
  localparam int unsigned RD_LSB  = 4;
  localparam int unsigned RS2_MSB = 3;
  localparam int unsigned RS2_LSB = 0;

  typedef enum logic [1:0] {NONE, I4, LUI8, JAL8} imm_kind_t;

  // b_from_rd: SW/BEQ take operand B from the rd field instead of rs2
  typedef struct packed {
    logic      uses_rs1;
    logic      uses_rs2;
    logic      b_from_rd;
    logic      writes_rd;
    logic      illegal;
    imm_kind_t imm_kind;
  } op_ctrl_t;

  function automatic op_ctrl_t decode_op(input logic [3:0] op);
    op_ctrl_t c;
    c = '0;
    c.imm_kind = NONE;
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR: begin
        c.uses_rs1  = 1'b1;
        c.uses_rs2  = 1'b1;
        c.writes_rd = 1'b1;
      end
      OP_ADDI, OP_LW: begin
        c.uses_rs1  = 1'b1;
        c.writes_rd = 1'b1;
        c.imm_kind  = I4;
      end
      OP_SW, OP_BEQ: begin
        c.uses_rs1  = 1'b1;
        c.b_from_rd = 1'b1;
        c.imm_kind  = I4;
      end
      OP_LUI: begin
        c.writes_rd = 1'b1;
        c.imm_kind  = LUI8;
      end
      OP_JAL: begin
        c.writes_rd = 1'b1;
        c.imm_kind  = JAL8;
      end
      default: c.illegal = 1'b1;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/regfile_2r1w.sv
// 16-entry register file, two combinational read ports, one write port, async clear.
// Optional same-cycle write-to-read bypass under DECODE_WB_BYPASS_EN.
module regfile_2r1w #(
  parameter int unsigned DW      = 16,
  parameter bit          R0_ZERO = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wb_en,
  input  logic [3:0]    wb_addr,
  input  logic [DW-1:0] wb_data,
  input  logic [3:0]    ra1,
  output logic [DW-1:0] rd1,
  input  logic [3:0]    ra2,
  output logic [DW-1:0] rd2
);

  logic [DW-1:0] mem [16];
  logic          wr_ok;

  assign wr_ok = wb_en & ~(R0_ZERO & (wb_addr == 4'd0));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < 16; i++) mem[i] <= '0;
    end else if (wr_ok) begin
      mem[wb_addr] <= wb_data;
    end
  end

  always_comb begin
    rd1 = mem[ra1];
`ifdef DECODE_WB_BYPASS_EN
    if (wr_ok && (wb_addr == ra1)) rd1 = wb_data;
`endif
    if (R0_ZERO && (ra1 == 4'd0)) rd1 = '0;
  end

  always_comb begin
    rd2 = mem[ra2];
`ifdef DECODE_WB_BYPASS_EN
    if (wr_ok && (wb_addr == ra2)) rd2 = wb_data;
`endif
    if (R0_ZERO && (ra2 == 4'd0)) rd2 = '0;
  end

endmodule

// File: rtl/decode_stage_pipe.sv
// Pipelined decode stage: decode, register read and immediate generation into a
// valid/ready register with flush and load-use stall. Option: DECODE_WB_BYPASS_EN.
module decode_stage_pipe
  import decode_pkg::*;
#(
  parameter int unsigned DW      = 16,
  parameter bit          R0_ZERO = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [15:0]   ir,
  input  logic [DW-1:0] pc,
  input  logic          flush,
  input  logic          wb_en,
  input  logic [3:0]    wb_addr,
  input  logic [DW-1:0] wb_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_pc,
  output logic [DW-1:0] out_a,
  output logic [DW-1:0] out_b,
  output logic [DW-1:0] out_imm,
  output logic [3:0]    out_op,
  output logic [3:0]    out_rd,
  output logic [3:0]    out_rs1,
  output logic [3:0]    out_rs2,
  output logic          out_regwrite,
  output logic          out_illegal
);

  logic [3:0]    op, rs1, rd, rs2f, rb_idx;
  logic [7:0]    imm8;
  op_ctrl_t      ctl;
  logic [DW-1:0] rdata_a, rdata_b, opa, opb, imm;
  logic          regwrite, hazard, load;

  assign op     = ir[OP_MSB:OP_LSB];
  assign rs1    = ir[RS1_MSB:RS1_LSB];
  assign rd     = ir[RD_MSB:RD_LSB];
  assign rs2f   = ir[RS2_MSB:RS2_LSB];
  assign imm8   = {rs1, rs2f};
  assign ctl    = decode_op(op);
  assign rb_idx = ctl.b_from_rd ? rd : rs2f;

  regfile_2r1w #(.DW(DW), .R0_ZERO(R0_ZERO)) u_rf (
    .clk     (clk),
    .rst     (rst),
    .wb_en   (wb_en),
    .wb_addr (wb_addr),
    .wb_data (wb_data),
    .ra1     (rs1),
    .rd1     (rdata_a),
    .ra2     (rb_idx),
    .rd2     (rdata_b)
  );

  assign opa      = ctl.uses_rs1 ? rdata_a : '0;
  assign opb      = (ctl.uses_rs2 | ctl.b_from_rd) ? rdata_b : '0;
  assign regwrite = ctl.writes_rd & ((rd != 4'd0) | ~R0_ZERO);

  always_comb begin
    imm = '0;
    case (ctl.imm_kind)
      I4:      imm = {{(DW-4){rs2f[3]}}, rs2f};
      LUI8:    imm[15:0] = {imm8, 8'h00};
      JAL8:    imm = {{(DW-9){imm8[7]}}, imm8, 1'b0};
      default: imm = '0;
    endcase
  end

  // Stall only when the held LW's destination feeds an operand this ir actually reads
  assign hazard = out_valid & (out_op == OP_LW) & (out_rd != 4'd0) &
                  ((ctl.uses_rs1  & (rs1  == out_rd)) |
                   (ctl.uses_rs2  & (rs2f == out_rd)) |
                   (ctl.b_from_rd & (rd   == out_rd)));

  assign in_ready = flush | ((~out_valid | out_ready) & ~hazard);
  assign load     = in_valid & in_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid    <= 1'b0;
      out_pc       <= '0;
      out_a        <= '0;
      out_b        <= '0;
      out_imm      <= '0;
      out_op       <= '0;
      out_rd       <= '0;
      out_rs1      <= '0;
      out_rs2      <= '0;
      out_regwrite <= 1'b0;
      out_illegal  <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (load) begin
      out_valid    <= 1'b1;
      out_pc       <= pc;
      out_a        <= opa;
      out_b        <= opb;
      out_imm      <= imm;
      out_op       <= op;
      out_rd       <= rd;
      out_rs1      <= rs1;
      out_rs2      <= rb_idx;
      out_regwrite <= regwrite;
      out_illegal  <= ctl.illegal;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_decode_stage_pipe.sv
// Self-checking bench for decode_stage_pipe: directed steps then random traffic,
// checked against a behavioural model of the decode stage and register file.
module tb_decode_stage_pipe;

  localparam int unsigned DW = 16;

  logic          clk, rst;
  logic          in_valid, in_ready, flush, wb_en, out_valid, out_ready;
  logic [15:0]   ir;
  logic [DW-1:0] pc, wb_data;
  logic [3:0]    wb_addr;
  logic [DW-1:0] out_pc, out_a, out_b, out_imm;
  logic [3:0]    out_op, out_rd, out_rs1, out_rs2;
  logic          out_regwrite, out_illegal;

  decode_stage_pipe #(.DW(DW), .R0_ZERO(1'b1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .ir(ir), .pc(pc),
    .flush(flush), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_a(out_a),
    .out_b(out_b), .out_imm(out_imm), .out_op(out_op), .out_rd(out_rd),
    .out_rs1(out_rs1), .out_rs2(out_rs2), .out_regwrite(out_regwrite),
    .out_illegal(out_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] pc, a, b, imm;
    logic [3:0]  op, rd, rs1, rs2;
    logic        rw, ill;
  } dec_t;

  int          n_cmp = 0;
  int          n_err = 0;
  dec_t        m_out;
  logic        m_valid;
  logic [15:0] m_rf [16];
  logic        last_ready;
  logic [15:0] exp_t2;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] m_read(input logic [3:0] idx);
    if (idx == 4'd0) return 16'h0;
`ifdef DECODE_WB_BYPASS_EN
    if (wb_en && wb_addr == idx) return wb_data;
`endif
    return m_rf[idx];
  endfunction

  function automatic bit m_reads(input logic [15:0] i, input logic [3:0] idx);
    int o;
    o = int'(i[15:12]);
    return (o <= 7 && i[11:8] == idx) || (o <= 3 && i[3:0] == idx) ||
           ((o == 6 || o == 7) && i[7:4] == idx);
  endfunction

  function automatic dec_t m_decode(input logic [15:0] i, input logic [15:0] p);
    dec_t d;
    int   o, v;
    o = int'(i[15:12]);
    d = '0;
    d.pc  = p;
    d.op  = i[15:12];
    d.rd  = i[7:4];
    d.rs1 = i[11:8];
    d.rs2 = (o == 6 || o == 7) ? i[7:4] : i[3:0];
    d.ill = (o >= 10);
    d.rw  = (o <= 5 || o == 8 || o == 9) && (i[7:4] != 4'd0);
    if (o <= 7) d.a = m_read(i[11:8]);
    if (o <= 3) d.b = m_read(i[3:0]);
    else if (o == 6 || o == 7) d.b = m_read(i[7:4]);
    if (o >= 4 && o <= 7) begin
      v = int'(i[3:0]);
      if (v >= 8) v -= 16;
      d.imm = 16'(v);
    end else if (o == 8) begin
      d.imm = 16'(int'({i[11:8], i[3:0]}) * 256);
    end else if (o == 9) begin
      v = int'({i[11:8], i[3:0]});
      if (v >= 128) v -= 256;
      d.imm = 16'(v * 2);
    end
    return d;
  endfunction

  // One clock: check in_ready before the edge, advance the model, check outputs after.
  task automatic cycle();
    dec_t nd;
    bit   haz, er;
    #1;
    haz = m_valid && m_out.op == 4'h5 && m_out.rd != 4'd0 && m_reads(ir, m_out.rd);
    er  = flush ? 1'b1 : ((!m_valid || out_ready) && !haz);
    last_ready = in_ready;
    check("in_ready", 32'(in_ready), 32'(er));
    nd = m_decode(ir, pc);
    @(posedge clk);
    if (flush) m_valid = 1'b0;
    else if (in_valid && er) begin m_out = nd; m_valid = 1'b1; end
    else if (out_ready) m_valid = 1'b0;
    if (wb_en && wb_addr != 4'd0) m_rf[wb_addr] = wb_data;
    #1;
    check("out_valid", 32'(out_valid), 32'(m_valid));
    check("out_pc", 32'(out_pc), 32'(m_out.pc));
    check("out_a", 32'(out_a), 32'(m_out.a));
    check("out_b", 32'(out_b), 32'(m_out.b));
    check("out_imm", 32'(out_imm), 32'(m_out.imm));
    check("out_idx", {16'h0, out_op, out_rd, out_rs1, out_rs2},
          {16'h0, m_out.op, m_out.rd, m_out.rs1, m_out.rs2});
    check("out_flags", {30'h0, out_regwrite, out_illegal}, {30'h0, m_out.rw, m_out.ill});
  endtask

  task automatic model_reset();
    m_valid = 1'b0;
    m_out   = '0;
    for (int i = 0; i < 16; i++) m_rf[i] = 16'h0;
  endtask

  initial begin
    rst = 1'b0; in_valid = 1'b0; flush = 1'b0; wb_en = 1'b0; out_ready = 1'b1;
    ir = 16'h0; pc = 16'h0; wb_addr = 4'h0; wb_data = 16'h0;
    model_reset();
    #12;
    check("rst_valid", 32'(out_valid), 32'h0);
    check("rst_out_a", 32'(out_a), 32'h0);
    check("rst_in_ready", 32'(in_ready), 32'h1);
    @(posedge clk); #1; rst = 1'b1;

    // 1: plain ADD
    wb_en = 1'b1; wb_addr = 4'd1; wb_data = 16'h1234; cycle();
    wb_addr = 4'd2; wb_data = 16'h0005; cycle();
    wb_en = 1'b0; in_valid = 1'b1; ir = 16'h0162; pc = 16'h0100; cycle();
    in_valid = 1'b0;
    check("t1_valid", 32'(out_valid), 32'h1);
    check("t1_a", 32'(out_a), 32'h1234);
    check("t1_b", 32'(out_b), 32'h0005);
    check("t1_rd", 32'(out_rd), 32'h6);
    check("t1_rw", 32'(out_regwrite), 32'h1);

    // 2: writeback in the same cycle as the read
    wb_en = 1'b1; wb_addr = 4'd3; wb_data = 16'hBEEF; in_valid = 1'b1; ir = 16'h0330; cycle();
    wb_en = 1'b0; in_valid = 1'b0;
`ifdef DECODE_WB_BYPASS_EN
    exp_t2 = 16'hBEEF;
`else
    exp_t2 = 16'h0000;
`endif
    check("t2_bypass", 32'(out_a), 32'(exp_t2));

    // 3: load-use stall
    in_valid = 1'b1; ir = 16'h5140; pc = 16'h0200; cycle();
    ir = 16'h0463; pc = 16'h0202; cycle();
    check("t3_stall_ready", 32'(last_ready), 32'h0);
    check("t3_bubble", 32'(out_valid), 32'h0);
    cycle();
    check("t3_accept_ready", 32'(last_ready), 32'h1);
    check("t3_valid", 32'(out_valid), 32'h1);
    check("t3_rs1", 32'(out_rs1), 32'h4);

    // 4: immediates
    ir = 16'h412F; cycle();
    check("t4_addi", 32'(out_imm), 32'hFFFF);
    ir = 16'h8A5B; cycle();
    check("t4_lui", 32'(out_imm), 32'hAB00);
    check("t4_lui_rd", 32'(out_rd), 32'h5);
    ir = 16'h9F0E; cycle();
    check("t4_jal", 32'(out_imm), 32'hFFFC);
    check("t4_jal_rw", 32'(out_regwrite), 32'h0);

    // 5: backpressure then flush
    out_ready = 1'b0; ir = 16'h1123; pc = 16'h0300;
    for (int k = 0; k < 3; k++) begin
      cycle();
      check("t5_ready", 32'(last_ready), 32'h0);
      check("t5_hold", 32'(out_imm), 32'hFFFC);
    end
    flush = 1'b1; cycle();
    flush = 1'b0; out_ready = 1'b1; in_valid = 1'b0;
    check("t5_flush", 32'(out_valid), 32'h0);

    // 6: illegal opcode
    in_valid = 1'b1; ir = 16'hF000; cycle();
    in_valid = 1'b0;
    check("t6_illegal", 32'(out_illegal), 32'h1);
    check("t6_rw", 32'(out_regwrite), 32'h0);

    // random traffic
    for (int k = 0; k < 400; k++) begin
      in_valid  = 1'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 15) == 0);
      wb_en     = 1'($urandom);
      wb_addr   = 4'($urandom_range(0, 7));
      wb_data   = 16'($urandom);
      pc        = 16'($urandom);
      ir = {4'($urandom_range(0, 15)), 4'($urandom_range(0, 7)),
            4'($urandom_range(0, 7)), 4'($urandom_range(0, 7))};
      cycle();
    end
    flush = 1'b0; wb_en = 1'b0;

    // reset mid-stream
    in_valid = 1'b1; out_ready = 1'b0; ir = 16'h0121; cycle();
    #2; rst = 1'b0; #1;
    model_reset();
    check("t6_rst_valid", 32'(out_valid), 32'h0);
    check("t6_rst_pc", 32'(out_pc), 32'h0);
    @(posedge clk); #1; rst = 1'b1;
    out_ready = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      ir = {4'h0, 4'(i), 4'h0, 4'(i)};
      cycle();
      check("t6_rf_zero", {out_a, out_b}, 32'h0);
    end
    in_valid = 1'b0;
    cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/decode_stage_pipe.md
Name: decode_stage_pipe

Overview:
Parametrised, pipelined successor to the single-cycle decode stage of the 16-bit processor. It decodes a 16-bit instruction, reads a 16-entry register file with a writeback write port, and generates the immediate. It registers the result into a valid/ready decode-to-execute pipeline register. It adds backpressure, a flush input, load-use hazard stalling and illegal-opcode flagging between fetch and execute.

Parameters:
DW, 16, data/register width in bits (>=16); pc, operands and immediate are DW bits wide.
R0_ZERO, 1, 1 = register 0 reads as zero and ignores writes; 0 = register 0 is an ordinary register.

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous active-low reset
in_valid  input  1  ir/pc valid from fetch
in_ready  output  1  decode accepts ir/pc this cycle
ir  input  16  instruction: op[15:12], rs1[11:8], rd[7:4], rs2[3:0]
pc  input  DW  pc of ir
flush  input  1  discard the held and incoming instruction
wb_en  input  1  register-file write enable (writeback)
wb_addr  input  4  write address
wb_data  input  DW  write data
out_valid  output  1  pipeline register holds an instruction
out_ready  input  1  execute accepts it
out_pc, out_a, out_b, out_imm  output  DW  registered pc, operand A, operand B, immediate
out_op  output  4  registered opcode
out_rd, out_rs1, out_rs2  output  4  destination and source indices, for execute forwarding
out_regwrite  output  1  instruction writes rd
out_illegal  output  1  opcode reserved

Behaviour:
- Reset (rst low, async): all out_* = 0, out_valid = 0, all register-file entries = 0. in_ready is combinational and follows the handshake rule below.
- Opcodes (package): 0 ADD, 1 SUB, 2 AND, 3 OR, 4 ADDI, 5 LW, 6 SW, 7 BEQ, 8 LUI, 9 JAL, A-F reserved.
- Operand A = reg[ir[11:8]] for ops 0-7, else 0.
- Operand B = reg[ir[3:0]] for ops 0-3; reg[ir[7:4]] for SW/BEQ; else 0. out_rs2 reports the index actually read.
- Immediate for ADDI/LW/SW/BEQ = sign-extended ir[3:0].
- Immediate for LUI/JAL: imm8 = {ir[11:8], ir[3:0]}. LUI gives zero-extended imm8<<8. JAL gives sign-extended imm8<<1. All other ops give 0.
- out_regwrite = 1 for ops 0-5, 8 and 9 when the decoded rd != 0 (or R0_ZERO = 0); otherwise 0.
- Reserved ops: out_illegal = 1, out_regwrite = 0, operands 0.
- Latency: one cycle. The instruction accepted at edge N appears on out_* after edge N.
- Handshake: in_ready = (!out_valid | out_ready) & !hazard, or 1 when flush = 1. The pipeline register loads when in_valid & in_ready.
- While out_valid & !out_ready, all out_* hold stable.
- Load-use hazard: hazard = out_valid & out_op == LW & out_rd != 0 & (an operand read by ir uses index out_rd). When hazard & out_ready, the register loads a bubble (out_valid = 0) and in_ready = 0. The next cycle accepts normally.
- Flush: synchronous and highest priority. out_valid becomes 0 next cycle. The incoming instruction is consumed (in_ready = 1) and discarded.
- Register file: written at the rising edge when wb_en is high (except reg 0 when R0_ZERO = 1). Reads are combinational. Operands held during a stall are not refreshed by later writebacks; execute forwards using out_rs1/out_rs2.
- A reset asserted mid-operation drops any held instruction and clears the register file.

Optional Feature:
DECODE_WB_BYPASS_EN.
- Defined: a read whose index equals wb_addr while wb_en is high (and the index is not reg 0 with R0_ZERO = 1) returns wb_data in the same cycle.
- Undefined: the read returns the pre-write value. Software or execute forwarding covers the gap.

Decomposition:
- Package decode_pkg: opcode localparams, field bit-position localparams, imm_kind_t enum (NONE/I4/LUI8/JAL8), the uses_rs1/uses_rs2/writes_rd decode function.
- One sub-module, regfile_2r1w: DW, R0_ZERO and the bypass macro, async clear.

Test Plan:
1. Write reg1 = 0x1234 and reg2 = 0x0005, then ir = 0x0162 (ADD) -> next cycle out_valid = 1, out_a = 0x1234, out_b = 0x0005, out_rd = 6, out_regwrite = 1.
2. wb_en with reg3 = 0xBEEF in the same cycle as ir = 0x0330 -> out_a = 0xBEEF with DECODE_WB_BYPASS_EN; without it, out_a = 0x0000.
3. ir = 0x5140 (LW rd = 4), then ir = 0x0463 (ADD reads r4), out_ready = 1 -> in_ready low for exactly one cycle, one bubble, then the ADD is presented with out_rs1 = 4.
4. Immediates: ADDI 0x412F -> out_imm = 0xFFFF; LUI 0x8A5B -> 0xAB00 with out_rd = 5; JAL 0x9F0E -> 0xFFFC with out_regwrite = 0.
5. Hold out_ready = 0 for 3 cycles with in_valid = 1 -> out_* stable and in_ready = 0. Then pulse flush -> out_valid = 0 next cycle.
6. ir = 0xF000 -> out_illegal = 1 and out_regwrite = 0. Assert rst mid-stream -> out_valid = 0 immediately and all registers read 0 afterwards.
